// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// One quotient bit per clock. Signed division divides operand magnitudes and
// applies the sign correction on the final iteration.
// result_o = {remainder, quotient}, both registered together with ready_o.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_FREE    = 2'b00,
        ST_BY_ZERO = 2'b01,
        ST_ON      = 2'b10,
        ST_END     = 2'b11
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   dvd, dvd_nxt;      // dividend, shifted out MSB first
    logic [WIDTH-1:0]   dvs, dvs_nxt;      // divisor magnitude
    logic [WIDTH-1:0]   rem, rem_nxt;      // partial remainder
    logic [WIDTH-1:0]   quo, quo_nxt;      // partial quotient
    logic               sign_q, sign_q_nxt;
    logic               sign_r, sign_r_nxt;
    logic [2*WIDTH-1:0] result_nxt;
    logic               ready_nxt;

    logic               accept;
    logic               abort;
    logic               last_iter;
    logic [WIDTH-1:0]   op1_mag, op2_mag;
    logic [WIDTH-1:0]   rem_sh, rem_step, quo_step, rem_fin, quo_fin;
    logic [WIDTH:0]     diff;

    assign accept    = start_i & ~annul_i;
    assign abort     = annul_i | ~start_i;
    assign last_iter = (cnt == LAST_CNT);

    // Operands enter the datapath as magnitudes for DIV, untouched for DIVU.
    // The most negative value maps onto itself, which is the correct unsigned magnitude.
    assign op1_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign op2_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // One restoring step. After k steps the partial remainder is below 2**k, so the
    // remainder MSB dropped by the shift is always zero before the final step.
    assign rem_sh   = {rem[WIDTH-2:0], dvd[WIDTH-1]};
    assign diff     = {1'b0, rem_sh} - {1'b0, dvs};
    assign rem_step = diff[WIDTH] ? rem_sh : diff[WIDTH-1:0];
    assign quo_step = {quo[WIDTH-2:0], ~diff[WIDTH]};

    // Sign correction applied to the last step's outputs (modulo 2**WIDTH).
    assign quo_fin = sign_q ? -quo_step : quo_step;
    assign rem_fin = sign_r ? -rem_step : rem_step;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process ordering.
        if (rst) begin
            state <= ST_FREE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned and no latch is inferred.
        state_nxt = state;
        unique case (state)
            ST_FREE: begin
                if (accept) begin
                    state_nxt = (opdata2_i == '0) ? ST_BY_ZERO : ST_ON;
                end
            end
            ST_BY_ZERO: begin
                state_nxt = abort ? ST_FREE : ST_END;
            end
            ST_ON: begin
                if (abort) begin
                    state_nxt = ST_FREE;
                end else if (last_iter) begin
                    state_nxt = ST_END;
                end
            end
            ST_END: begin
                state_nxt = start_i ? ST_END : ST_FREE;
            end
            default: state_nxt = ST_FREE;
        endcase
    end

    // Output and datapath next values: operand capture, iteration, result publish.
    always_comb begin
        cnt_nxt    = cnt;
        dvd_nxt    = dvd;
        dvs_nxt    = dvs;
        rem_nxt    = rem;
        quo_nxt    = quo;
        sign_q_nxt = sign_q;
        sign_r_nxt = sign_r;
        result_nxt = result_o;
        ready_nxt  = ready_o;
        unique case (state)
            ST_FREE: begin
                result_nxt = '0;
                ready_nxt  = 1'b0;
                if (accept) begin
                    cnt_nxt    = '0;
                    dvd_nxt    = op1_mag;
                    dvs_nxt    = op2_mag;
                    rem_nxt    = '0;
                    quo_nxt    = '0;
                    sign_q_nxt = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    sign_r_nxt = signed_div_i & opdata1_i[WIDTH-1];
                end
            end
            ST_BY_ZERO: begin
                // Entering END with a zero result; ready_o rises on the following edge.
                result_nxt = '0;
                ready_nxt  = 1'b0;
            end
            ST_ON: begin
                if (abort) begin
                    result_nxt = '0;
                    ready_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    dvd_nxt = {dvd[WIDTH-2:0], 1'b0};
                    rem_nxt = rem_step;
                    quo_nxt = quo_step;
                    if (last_iter) begin
                        result_nxt = {rem_fin, quo_fin};
                        ready_nxt  = 1'b1;
                    end
                end
            end
            ST_END: begin
                // Result held while execute keeps start_i high; cleared once it lets go.
                if (start_i) begin
                    ready_nxt = 1'b1;
                end else begin
                    result_nxt = '0;
                    ready_nxt  = 1'b0;
                end
            end
            default: begin
                result_nxt = '0;
                ready_nxt  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the operand and partial-result registers are reset too, so a
            // reset leaves no stale quotient bits that could ever be observed.
            cnt      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            quo      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            dvd      <= dvd_nxt;
            dvs      <= dvs_nxt;
            rem      <= rem_nxt;
            quo      <= quo_nxt;
            sign_q   <= sign_q_nxt;
            sign_r   <= sign_r_nxt;
            result_o <= result_nxt;
            ready_o  <= ready_nxt;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed, table-driven bench for div_unit with hand-computed
// expected {remainder, quotient} values and latencies.
module tb_div_unit;

    localparam int WIDTH   = 32;
    localparam int MAX_LAT = 40;

    logic               clk = 1'b0;
    logic               rst;
    logic               start_i;
    logic               annul_i;
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rem;
        logic [31:0] quo;
        int          lat;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept an operation on the next edge, then wait (bounded) for ready_o.
    // Leaves start_i high so the caller controls the END hold time.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_res, input int exp_lat,
                          input string tag, input bit toggle_ops);
        int lat;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        tick();
        lat = 0;
        while (lat <= MAX_LAT) begin
            if (toggle_ops) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
            end
            tick();
            lat++;
            if (ready_o) break;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, result_o, exp_res);
    endtask

    // Release start_i; the very next edge must clear ready_o and result_o.
    task automatic drop_start(input string tag);
        start_i = 1'b0;
        tick();
        check({tag, "_drop_ready"}, 64'(ready_o), 64'd0);
        check({tag, "_drop_result"}, result_o, 64'd0);
    endtask

    initial begin
        logic [63:0] held;
        bit          seen_ready;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,        32'h00000002, 32'h0000000E, 32};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 32};
        vecs[2]  = '{1'b1, 32'h00000007,   32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 32};
        vecs[3]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 32};
        vecs[4]  = '{1'b0, 32'hFFFFFFF9,   32'h00000002, 32'h00000001, 32'h7FFFFFFC, 32};
        vecs[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32};
        vecs[6]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32};
        vecs[7]  = '{1'b0, 32'd5,          32'd0,        32'h00000000, 32'h00000000, 2};
        vecs[8]  = '{1'b1, 32'hFFFFFFF9,   32'd0,        32'h00000000, 32'h00000000, 2};
        vecs[9]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32};
        vecs[10] = '{1'b0, 32'h12345678,   32'h00001000, 32'h00000678, 32'h00012345, 32};
        vecs[11] = '{1'b1, 32'h80000000,   32'h00000002, 32'h00000000, 32'hC0000000, 32};
        vecs[12] = '{1'b0, 32'd3,          32'd5,        32'h00000003, 32'h00000000, 32};
        vecs[13] = '{1'b1, 32'hFFFFFF9C,   32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2, 32};
        vecs[14] = '{1'b0, 32'hFFFFFFFF,   32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32};

        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        tick();
        tick();
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b0;
        tick();

        // Table: each vector runs back to back with the minimum one-cycle start_i gap.
        // Odd vectors scramble the operand inputs while the division is in flight.
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, {vecs[i].rem, vecs[i].quo},
                   vecs[i].lat, $sformatf("vec%0d", i), bit'(i % 2));
            drop_start($sformatf("vec%0d", i));
        end

        // Wrap case with operands scrambled every cycle.
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 32, "wrap_toggle", 1'b1);
        drop_start("wrap_toggle");

        // Hold start_i for 5 cycles after ready_o; annul_i and operands must be ignored.
        run_op(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 32, "hold", 1'b0);
        held = {32'h2, 32'hE};
        for (int k = 0; k < 5; k++) begin
            annul_i   = 1'($urandom);
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            tick();
            check($sformatf("hold%0d_ready", k), 64'(ready_o), 64'd1);
            check($sformatf("hold%0d_result", k), result_o, held);
        end
        annul_i = 1'b0;
        drop_start("hold");

        // Annul after 10 iterations; the annulled op must never raise ready_o.
        start_i      = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        tick();
        for (int k = 0; k < 10; k++) tick();
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0;
        start_i = 1'b0;
        seen_ready = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (ready_o) seen_ready = 1'b1;
        end
        check("annul_no_ready", 64'(seen_ready), 64'd0);
        check("annul_result", result_o, 64'd0);
        run_op(1'b0, 32'hFFFFFFFF, 32'h1, {32'h0, 32'hFFFFFFFF}, 32, "after_annul", 1'b0);
        drop_start("after_annul");

        // Dropping start_i mid-ON also abandons the division.
        start_i   = 1'b1;
        opdata1_i = 32'd77;
        opdata2_i = 32'd5;
        tick();
        for (int k = 0; k < 6; k++) tick();
        start_i = 1'b0;
        seen_ready = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (ready_o) seen_ready = 1'b1;
        end
        check("startdrop_no_ready", 64'(seen_ready), 64'd0);

        // Annul while in BY_ZERO returns to FREE with no result.
        start_i   = 1'b1;
        opdata1_i = 32'd9;
        opdata2_i = 32'd0;
        tick();
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0;
        start_i = 1'b0;
        seen_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (ready_o) seen_ready = 1'b1;
        end
        check("byzero_annul_no_ready", 64'(seen_ready), 64'd0);

        // start_i with annul_i in FREE is not an accept.
        start_i   = 1'b1;
        annul_i   = 1'b1;
        opdata1_i = 32'd50;
        opdata2_i = 32'd0;
        seen_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (ready_o) seen_ready = 1'b1;
        end
        check("free_annul_no_accept", 64'(seen_ready), 64'd0);
        start_i = 1'b0;
        annul_i = 1'b0;
        tick();

        // Synchronous reset mid-ON.
        start_i      = 1'b1;
        signed_div_i = 1'b1;
        opdata1_i    = 32'hFFFFFFF9;
        opdata2_i    = 32'h2;
        tick();
        for (int k = 0; k < 7; k++) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_ready", 64'(ready_o), 64'd0);
        check("rst_mid_result", result_o, 64'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        tick();
        check("rst_after_ready", 64'(ready_o), 64'd0);
        run_op(1'b1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 32, "after_rst", 1'b0);
        drop_start("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
